// File: rtl/rgb_led_pkg.sv
// Shared constants for the on-board RGB LED: pin indices, active-low base colours,
// and the system clock rate.
package rgb_led_pkg;

  // Bit positions of each colour within the 3-bit active-low LED bus.
  localparam int unsigned LED_R = 2;
  localparam int unsigned LED_B = 1;
  localparam int unsigned LED_G = 0;

  // Active-low base colours in {R, B, G} pin order; a 0 bit lights that die.
  localparam logic [2:0] WHITE   = 3'b000;
  localparam logic [2:0] MAGENTA = 3'b001;
  localparam logic [2:0] YELLOW  = 3'b010;
  localparam logic [2:0] RED     = 3'b011;
  localparam logic [2:0] CYAN    = 3'b100;
  localparam logic [2:0] BLUE    = 3'b101;
  localparam logic [2:0] GREEN   = 3'b110;
  localparam logic [2:0] OFF     = 3'b111;

  localparam int unsigned CLK_HZ = 24_000_000;

endpackage

// File: rtl/pwm_frame_timer.sv
// PWM timebase: a prescaler that produces one step_tick every PRESCALE clocks and a
// DUTY_W-bit step counter whose last tick marks the end of a PWM frame.
module pwm_frame_timer
  import rgb_led_pkg::*;
#(
  parameter int unsigned DUTY_W   = 8,
  parameter int unsigned PRESCALE = 94
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DUTY_W-1:0] step_cnt,
  output logic              step_tick,
  output logic              frame_end
);

  // Keep the prescaler at least one bit wide so PRESCALE=1 still elaborates.
  localparam int unsigned     PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] prescaler;

  assign step_tick = (prescaler == PS_MAX);
  assign frame_end = step_tick && (step_cnt == {DUTY_W{1'b1}});

  // Prescaler wraps on step_tick; the step counter advances on it and wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      step_cnt  <= '0;
    end else begin
      if (step_tick) begin
        prescaler <= '0;
        step_cnt  <= step_cnt + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgb_pwm_led.sv
// RGB LED output stage: accepts colour commands over valid/ready into a one-deep
// buffer, applies brightness scaling at PWM frame boundaries, and drives the
// active-low LED pins with registered PWM comparators.
module rgb_pwm_led
  import rgb_led_pkg::*;
#(
  parameter int unsigned DUTY_W   = 8,
  parameter int unsigned PRESCALE = 94
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              color_valid,
  output logic              color_ready,
  input  logic [DUTY_W-1:0] color_r,
  input  logic [DUTY_W-1:0] color_g,
  input  logic [DUTY_W-1:0] color_b,
  input  logic [DUTY_W-1:0] brightness,
  output logic              frame_start,
  output logic [2:0]        led
);

  localparam int unsigned PROD_W = 2 * DUTY_W + 1;

  // (c * (br + 1)) >> DUTY_W; br = max passes c through unchanged, br = 0 yields 0.
  function automatic logic [DUTY_W-1:0] scale(input logic [DUTY_W-1:0] c,
                                               input logic [DUTY_W-1:0] br);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(c) * (PROD_W'(br) + PROD_W'(1));
    return DUTY_W'(prod >> DUTY_W);
  endfunction

  logic [DUTY_W-1:0] step_cnt;
  logic              step_tick;
  logic              frame_end;

  logic              pending_full;
  logic [DUTY_W-1:0] pending_r, pending_g, pending_b;
  logic [DUTY_W-1:0] duty_r, duty_g, duty_b;

  pwm_frame_timer #(
    .DUTY_W   (DUTY_W),
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .step_cnt  (step_cnt),
    .step_tick (step_tick),
    .frame_end (frame_end)
  );

  assign color_ready = !pending_full;

  // Command capture and frame-boundary duty update. Accept and apply never coincide
  // because ready is low whenever the buffer holds a command.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_full <= 1'b0;
      pending_r    <= '0;
      pending_g    <= '0;
      pending_b    <= '0;
      duty_r       <= '0;
      duty_g       <= '0;
      duty_b       <= '0;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (color_valid && !pending_full) begin
        pending_r    <= color_r;
        pending_g    <= color_g;
        pending_b    <= color_b;
        pending_full <= 1'b1;
      end
      if (frame_end && pending_full) begin
        duty_r       <= scale(pending_r, brightness);
        duty_g       <= scale(pending_g, brightness);
        duty_b       <= scale(pending_b, brightness);
        pending_full <= 1'b0;
        frame_start  <= 1'b1;
      end
    end
  end

  // Registered comparators keep the pins glitch-free; one clk behind step_cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= OFF;
    end else begin
      led[LED_R] <= ~(step_cnt < duty_r);
      led[LED_B] <= ~(step_cnt < duty_b);
      led[LED_G] <= ~(step_cnt < duty_g);
    end
  end

endmodule

// File: doc/rgb_pwm_led.md
Name: rgb_pwm_led

Overview:
Downstream output stage for the on-board RGB LED. It accepts 8-bit-per-channel colour commands from a colour generator (for example the rainbow sequencer) over a valid/ready handshake. It applies a global brightness scale and drives the active-low 3-bit LED pins with glitch-free PWM. New colours take effect only at PWM frame boundaries, so there are no partial-frame artefacts.

Parameters:
- DUTY_W, 8, width of each channel's duty value and of the PWM step counter; frame = 2^DUTY_W steps.
- PRESCALE, 94, clk cycles per PWM step (24 MHz / (94*256) ≈ 997 Hz frame rate); minimum 1.

Ports:
- clk  in  1  system clock (24 MHz).
- rst  in  1  synchronous, active-high reset.
- color_valid  in  1  colour command present.
- color_ready  out  1  block can accept a command this cycle.
- color_r  in  DUTY_W  red intensity.
- color_g  in  DUTY_W  green intensity.
- color_b  in  DUTY_W  blue intensity.
- brightness  in  DUTY_W  global scale, sampled at frame boundary.
- frame_start  out  1  one-cycle pulse when new duties become active.
- led  out  3  active-low LED pins: led[2]=red, led[1]=blue, led[0]=green.

Behaviour:
- Reset (rst=1 at a clk edge) clears every register in that cycle, including mid-frame:
  - led=3'b111 (all off), frame_start=0;
  - prescaler=0, step counter=0;
  - active duties=0, pending buffer empty.
  - color_ready reads 1 from the first cycle after rst deasserts.
- Prescaler:
  - Counts 0..PRESCALE-1.
  - step_tick is high in the cycle where prescaler==PRESCALE-1; the prescaler then wraps to 0.
- Step counter:
  - DUTY_W bits; increments on step_tick and wraps 2^DUTY_W-1 -> 0.
  - frame_end = step_tick && step counter at maximum.
- Handshake:
  - One-deep pending buffer; color_ready = !pending_full.
  - Transfer occurs when color_valid && color_ready; r/g/b are captured into pending and pending_full is set.
  - color_valid while not ready: the command is held by the producer and not captured.
- Frame boundary (frame_end cycle), when pending_full:
  - Each active duty_x <= (pending_x * (brightness+1)) >> DUTY_W, using a 2*DUTY_W+1-bit product truncated to DUTY_W bits.
  - pending_full is cleared and frame_start is pulsed on the next cycle.
- Frame boundary without pending_full:
  - Active duties are held unchanged, brightness is not re-sampled, and no frame_start pulse is issued.
- Simultaneous accept and frame_end: not possible, because ready is low whenever pending is full. An accept in the frame_end cycle with pending empty captures into pending and applies at the next frame_end.
- Output:
  - led[i] <= ~(step_cnt < duty_i), registered, so there is one clk of latency from the counter.
  - duty 0 -> the pin stays high (off) for the whole frame.
  - duty 2^DUTY_W-1 -> the pin is low for 255 of 256 steps.
- Brightness:
  - brightness=2^DUTY_W-1 gives the unscaled colour (pending_x*256>>8 = pending_x).
  - brightness=0 gives pending_x>>8 = 0, so the LED is fully off.
- Worst-case command-to-light latency is one full frame plus 2 clk.

Decomposition:
- Shared package rgb_led_pkg:
  - LED bit index constants: LED_R=2, LED_B=1, LED_G=0.
  - 3-bit base-colour constants: WHITE=000, MAGENTA=001, YELLOW=010, RED=011, CYAN=100, BLUE=101, GREEN=110, OFF=111.
  - CLK_HZ=24_000_000.
- One natural sub-module, pwm_frame_timer: prescaler plus step counter, exposing step_cnt, step_tick and frame_end. The handshake, scaling and comparators stay in the top level.

Test Plan (PRESCALE=1, DUTY_W=8, frame = 256 clk):
- Reset: hold rst 3 clk mid-frame with duties nonzero -> led=111 and frame_start=0 on the cycle after the rst edge; color_ready=1 one cycle after release; step_cnt restarts at 0.
- Basic duty: send r=128,g=0,b=255, brightness=255, then wait for frame_start.
  - Next frame: led[2] low for exactly 128 clk, led[0] never low, led[1] low for 255 clk.
  - Then check a frame with a new frame_start -> counts repeat.
- Backpressure: two back-to-back commands (r=10 then r=200) -> the second is stalled with color_ready=0 until the frame_end after the first is accepted. The r=10 frame shows 10 low cycles; the r=200 frame follows one frame later.
- Brightness scaling: r=200, brightness=127 -> duty_r = 200*128>>8 = 100, so 100 low cycles. brightness=0 -> led[2] stays high for the whole frame.
- Boundary timing: accept a command in the exact frame_end cycle with pending empty -> no change this frame; frame_start follows the next frame_end; led changes only at step_cnt=0.
- PRESCALE=3 regression: duty 64 -> led[2] low for 192 clk of the 768 clk frame; frame_start period is 768 clk.
